proc_job_sequencer: RTL and testbench
=====================================

Name: proc_job_sequencer

Overview:
- Sequences the image processing pipeline through an ordered list of up to NUM_JOBS filter passes.
- For each pass it applies that job's gamma, inverse-gamma, bound and coefficient-bank configuration, strobes the pipeline GO, and waits for DONE.
- It enforces a microsecond timeout, supports continuous looping and abort, and reports per-job timing and status to the host register interface.

Parameters:
NUM_JOBS, 4, number of job table entries (power of two)
JOB_W, 2, log2(NUM_JOBS)
SETTLE_CYC, 4, cycles config outputs are held stable before GO (1..15)
TIMEOUT_US, 100000, max microseconds from GO to DONE before error

Ports:
CLK  in  1  master clock
RST  in  1  synchronous active-high reset
TICK_1US  in  1  one-cycle pulse every microsecond
CFG_WE  in  1  job table write strobe
CFG_ADDR  in  JOB_W  job table index
CFG_DATA  in  8  [0]GAMMA_EN [1]INVGAMMA_EN [2]BOUND_ABS [3]reserved [7:4]COEFF_SEL
SEQ_LEN  in  JOB_W+1  number of jobs to run (1..NUM_JOBS)
SEQ_START  in  1  start strobe
SEQ_ABORT  in  1  abort strobe
LOOP_EN  in  1  restart at job 0 after last job
PROC_BUSY  in  1  pipeline busy
PROC_DONE  in  1  pipeline frame-done strobe
PROC_GO  out  1  one-cycle pipeline start strobe
GAMMA_EN  out  1  applied gamma enable
INVGAMMA_EN  out  1  applied inverse-gamma enable
BOUND_ABS  out  1  applied bound mode
COEFF_SEL  out  4  coefficient bank select
SEQ_BUSY  out  1  sequence in progress
SEQ_DONE  out  1  one-cycle strobe, sequence completed normally
SEQ_ERR  out  2  0 none, 1 timeout, 2 aborted, 3 bad SEQ_LEN
JOB_IDX  out  JOB_W  current/last job index
JOB_TIME_US  out  24  duration of last completed job
LOOP_CNT  out  16  completed full passes while looping

Behaviour:
- Reset values:
  - All outputs 0.
  - Job table entries all 0.
  - State IDLE.
- Job table:
  - Written on CFG_WE only when SEQ_BUSY=0.
  - Writes while busy are ignored.
  - Read combinationally by the FSM.
- States: IDLE, SETUP, GO, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - SEQ_START with SEQ_LEN in 1..NUM_JOBS → SETUP at job 0. On that same edge: SEQ_BUSY=1, SEQ_ERR=0, LOOP_CNT=0.
  - SEQ_START with SEQ_LEN=0 or SEQ_LEN>NUM_JOBS → SEQ_ERR=3 and stay IDLE.
  - SEQ_START while busy is ignored.
- SETUP:
  - On entry edge: GAMMA_EN, INVGAMMA_EN, BOUND_ABS, COEFF_SEL and JOB_IDX are registered from table[job].
  - Held SETTLE_CYC cycles, then GO.
- GO:
  - PROC_GO=1 for exactly one cycle.
  - Timeout counter cleared.
  - Next state WAIT_DONE.
  - PROC_GO rises SETTLE_CYC+1 cycles after the SEQ_START edge.
- WAIT_DONE:
  - Counter increments on TICK_1US.
  - PROC_DONE → JOB_TIME_US=counter, then NEXT.
  - Counter reaching TIMEOUT_US → SEQ_ERR=1, then FINISH.
  - PROC_DONE and timeout in the same cycle: DONE wins.
  - PROC_BUSY is monitored only to qualify DONE: a DONE with PROC_BUSY never seen high since GO is still accepted.
- NEXT:
  - job+1 < SEQ_LEN → SETUP with job+1.
  - Otherwise LOOP_EN=1 → LOOP_CNT+1 (saturating at FFFF), SETUP with job 0.
  - Otherwise FINISH.
- FINISH:
  - SEQ_DONE=1 for one cycle, only if SEQ_ERR=0.
  - SEQ_BUSY=0 on the following edge; return to IDLE.
  - Config outputs keep their last values.
- SEQ_ABORT in any non-IDLE state:
  - Next edge → SEQ_ERR=2, SEQ_BUSY=0, IDLE.
  - PROC_GO is forced 0 on that edge; no SEQ_DONE.
  - Abort has priority over DONE, timeout and START in the same cycle.
  - SEQ_ABORT in IDLE has no effect.
- RST mid-sequence: all state and outputs return to reset values on the next edge. A pending pipeline DONE arriving afterwards is ignored in IDLE.
- PROC_DONE outside WAIT_DONE is ignored.
- LOOP_EN is sampled in NEXT, so clearing it mid-sequence ends the sequence after the current pass.

Test Plan:
- Single job: table[0]=8'h35, SEQ_LEN=1, START; DONE 20 ticks after GO → GAMMA_EN=1, BOUND_ABS=1, COEFF_SEL=3 from the START+1 edge; PROC_GO single pulse at START+5 with SETTLE_CYC=4; JOB_TIME_US=20; SEQ_DONE one pulse; SEQ_BUSY low after.
- Three jobs with distinct COEFF_SEL 1, 2, 3 → exactly 3 GO pulses, COEFF_SEL sequence 1, 2, 3, each config stable ≥4 cycles before its GO, JOB_IDX ends at 2.
- Timeout: TIMEOUT_US=50, pipeline never DONE → SEQ_ERR=1 after 50 ticks, no SEQ_DONE, SEQ_BUSY=0. A late DONE then changes nothing.
- Loop: SEQ_LEN=2, LOOP_EN=1, 3 passes, then LOOP_EN=0 → LOOP_CNT=3, 8 GO pulses total, then SEQ_DONE.
- Abort coincident with PROC_DONE in WAIT_DONE → SEQ_ERR=2, JOB_TIME_US unchanged, no further GO. CFG_WE during busy leaves the table unchanged.
- SEQ_LEN=0 START → SEQ_ERR=3, no GO. RST mid-SETUP → all outputs 0 next cycle.

Source files
------------

// File: rtl/proc_job_sequencer_if.sv
// Host/pipeline signal bundle for the job sequencer.
// The slave modport is the sequencer's view; the master modport drives it.
interface proc_job_sequencer_if #(
  parameter int unsigned JOB_W = 2
);
  logic             TICK_1US;
  logic             CFG_WE;
  logic [JOB_W-1:0] CFG_ADDR;
  logic [7:0]       CFG_DATA;
  logic [JOB_W:0]   SEQ_LEN;
  logic             SEQ_START;
  logic             SEQ_ABORT;
  logic             LOOP_EN;
  logic             PROC_BUSY;
  logic             PROC_DONE;
  logic             PROC_GO;
  logic             GAMMA_EN;
  logic             INVGAMMA_EN;
  logic             BOUND_ABS;
  logic [3:0]       COEFF_SEL;
  logic             SEQ_BUSY;
  logic             SEQ_DONE;
  logic [1:0]       SEQ_ERR;
  logic [JOB_W-1:0] JOB_IDX;
  logic [23:0]      JOB_TIME_US;
  logic [15:0]      LOOP_CNT;

  modport slave (
    input  TICK_1US, CFG_WE, CFG_ADDR, CFG_DATA, SEQ_LEN, SEQ_START,
           SEQ_ABORT, LOOP_EN, PROC_BUSY, PROC_DONE,
    output PROC_GO, GAMMA_EN, INVGAMMA_EN, BOUND_ABS, COEFF_SEL, SEQ_BUSY,
           SEQ_DONE, SEQ_ERR, JOB_IDX, JOB_TIME_US, LOOP_CNT
  );

  modport master (
    output TICK_1US, CFG_WE, CFG_ADDR, CFG_DATA, SEQ_LEN, SEQ_START,
           SEQ_ABORT, LOOP_EN, PROC_BUSY, PROC_DONE,
    input  PROC_GO, GAMMA_EN, INVGAMMA_EN, BOUND_ABS, COEFF_SEL, SEQ_BUSY,
           SEQ_DONE, SEQ_ERR, JOB_IDX, JOB_TIME_US, LOOP_CNT
  );
endinterface

// File: rtl/proc_job_sequencer.sv
// Steps the image pipeline through a small job table: applies each job's
// config, strobes GO after a settle period, times the pass and reports status.
module proc_job_sequencer #(
  parameter int unsigned NUM_JOBS   = 4,
  parameter int unsigned JOB_W      = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TIMEOUT_US = 100000
) (
  input  logic                  CLK,
  input  logic                  RST,
  proc_job_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GO,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH
  } state_e;

  // Table entry keeps {COEFF_SEL, BOUND_ABS, INVGAMMA_EN, GAMMA_EN}; bit 3 is reserved.
  logic [6:0]       tab_q [NUM_JOBS];

  state_e           state_q, state_d;
  logic [JOB_W-1:0] job_q, job_d;
  logic [JOB_W:0]   len_q, len_d;
  logic [3:0]       settle_q, settle_d;
  logic [23:0]      timer_q, timer_d;
  logic [23:0]      job_time_q, job_time_d;
  logic [15:0]      loop_cnt_q, loop_cnt_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             go_q, go_d;
  logic             done_q, done_d;
  logic             gamma_q, gamma_d;
  logic             invg_q, invg_d;
  logic             bound_q, bound_d;
  logic [3:0]       coeff_q, coeff_d;

  logic             ld_en;
  logic [JOB_W-1:0] ld_idx;
  logic [6:0]       ld_cfg;
  logic             len_bad;
  logic             last_job;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.PROC_BUSY, bus.CFG_DATA[3]};

  assign len_bad  = (bus.SEQ_LEN == '0) || (bus.SEQ_LEN > (JOB_W+1)'(NUM_JOBS));
  assign last_job = !(({1'b0, job_q} + (JOB_W+1)'(1)) < len_q);
  assign ld_cfg   = tab_q[ld_idx];

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    len_d      = len_q;
    settle_d   = settle_q;
    timer_d    = timer_q;
    job_time_d = job_time_q;
    loop_cnt_d = loop_cnt_q;
    err_d      = err_q;
    busy_d     = busy_q;
    go_d       = 1'b0;
    done_d     = 1'b0;
    gamma_d    = gamma_q;
    invg_d     = invg_q;
    bound_d    = bound_q;
    coeff_d    = coeff_q;
    ld_en      = 1'b0;
    ld_idx     = '0;

    // Abort outranks every other event, including a coincident DONE or timeout.
    if (state_q != S_IDLE && bus.SEQ_ABORT) begin
      state_d = S_IDLE;
      err_d   = 2'd2;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.SEQ_START) begin
            if (len_bad) begin
              err_d = 2'd3;
            end else begin
              state_d    = S_SETUP;
              busy_d     = 1'b1;
              err_d      = 2'd0;
              loop_cnt_d = '0;
              len_d      = bus.SEQ_LEN;
              ld_en      = 1'b1;
              ld_idx     = '0;
            end
          end
        end
        S_SETUP: begin
          if (settle_q == 4'(SETTLE_CYC)) begin
            state_d = S_GO;
            go_d    = 1'b1;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        S_GO: begin
          timer_d = '0;
          state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.PROC_DONE) begin
            job_time_d = timer_q;
            state_d    = S_NEXT;
          end else if (bus.TICK_1US) begin
            timer_d = timer_q + 24'd1;
            if ((32'(timer_q) + 32'd1) >= TIMEOUT_US) begin
              err_d   = 2'd1;
              state_d = S_FINISH;
            end
          end
        end
        S_NEXT: begin
          if (!last_job) begin
            state_d = S_SETUP;
            ld_en   = 1'b1;
            ld_idx  = job_q + JOB_W'(1);
          end else if (bus.LOOP_EN) begin
            if (loop_cnt_q != '1) loop_cnt_d = loop_cnt_q + 16'd1;
            state_d = S_SETUP;
            ld_en   = 1'b1;
            ld_idx  = '0;
          end else begin
            state_d = S_FINISH;
            done_d  = (err_q == 2'd0);
          end
        end
        S_FINISH: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (ld_en) begin
      job_d    = ld_idx;
      settle_d = '0;
      gamma_d  = ld_cfg[0];
      invg_d   = ld_cfg[1];
      bound_d  = ld_cfg[2];
      coeff_d  = ld_cfg[6:3];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_JOBS; i++) tab_q[i] <= '0;
      state_q    <= S_IDLE;
      job_q      <= '0;
      len_q      <= '0;
      settle_q   <= '0;
      timer_q    <= '0;
      job_time_q <= '0;
      loop_cnt_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
      gamma_q    <= 1'b0;
      invg_q     <= 1'b0;
      bound_q    <= 1'b0;
      coeff_q    <= '0;
    end else begin
      if (bus.CFG_WE && !busy_q)
        tab_q[bus.CFG_ADDR] <= {bus.CFG_DATA[7:4], bus.CFG_DATA[2:0]};
      state_q    <= state_d;
      job_q      <= job_d;
      len_q      <= len_d;
      settle_q   <= settle_d;
      timer_q    <= timer_d;
      job_time_q <= job_time_d;
      loop_cnt_q <= loop_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      go_q       <= go_d;
      done_q     <= done_d;
      gamma_q    <= gamma_d;
      invg_q     <= invg_d;
      bound_q    <= bound_d;
      coeff_q    <= coeff_d;
    end
  end

  assign bus.PROC_GO     = go_q;
  assign bus.GAMMA_EN    = gamma_q;
  assign bus.INVGAMMA_EN = invg_q;
  assign bus.BOUND_ABS   = bound_q;
  assign bus.COEFF_SEL   = coeff_q;
  assign bus.SEQ_BUSY    = busy_q;
  assign bus.SEQ_DONE    = done_q;
  assign bus.SEQ_ERR     = err_q;
  assign bus.JOB_IDX     = job_q;
  assign bus.JOB_TIME_US = job_time_q;
  assign bus.LOOP_CNT    = loop_cnt_q;

endmodule

// File: tb/tb_proc_job_sequencer.sv
// Directed bench for proc_job_sequencer with hand-computed expectations.
module tb_proc_job_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_job_sequencer_if #(.JOB_W(2)) bus ();

  proc_job_sequencer #(
    .NUM_JOBS(4), .JOB_W(2), .SETTLE_CYC(4), .TIMEOUT_US(50)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int go_cnt = 0;
  int done_cnt = 0;
  int stable = 0;
  int min_stable = 1000;
  logic [3:0] coeff_log [16];
  logic [6:0] prev_cfg = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse and config-stability monitor.
  always @(negedge clk) begin
    if ({bus.COEFF_SEL, bus.BOUND_ABS, bus.INVGAMMA_EN, bus.GAMMA_EN} != prev_cfg) stable = 1;
    else stable++;
    prev_cfg = {bus.COEFF_SEL, bus.BOUND_ABS, bus.INVGAMMA_EN, bus.GAMMA_EN};
    if (bus.PROC_GO) begin
      if (go_cnt < 16) coeff_log[go_cnt] = bus.COEFF_SEL;
      if (stable < min_stable) min_stable = stable;
      go_cnt++;
    end
    if (bus.SEQ_DONE) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.CFG_WE = 1'b1; bus.CFG_ADDR = a; bus.CFG_DATA = d;
    cyc(1);
    bus.CFG_WE = 1'b0;
  endtask

  task automatic start(input logic [2:0] len);
    bus.SEQ_LEN = len; bus.SEQ_START = 1'b1;
    cyc(1);
    bus.SEQ_START = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      bus.TICK_1US = 1'b1; cyc(1);
      bus.TICK_1US = 1'b0; cyc(1);
    end
  endtask

  // Returns at the negedge inside the GO cycle; n = negedges skipped before it.
  task automatic wait_go(output int n);
    bit ok = 0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      if (bus.PROC_GO) ok = 1; else n++;
    end
    if (!ok) check_eq("go_wait_expired", 64'(ok), 64'd1);
  endtask

  task automatic finish_job(input int ticks);
    @(posedge clk); #1;
    tick(ticks);
    bus.PROC_DONE = 1'b1; cyc(1);
    bus.PROC_DONE = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.SEQ_BUSY === 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) check_eq("idle_wait_expired", 64'(bus.SEQ_BUSY), 64'd0);
    cyc(1);
  endtask

  function automatic logic [63:0] all_outs();
    return {10'd0, bus.PROC_GO, bus.GAMMA_EN, bus.INVGAMMA_EN, bus.BOUND_ABS,
            bus.COEFF_SEL, bus.SEQ_BUSY, bus.SEQ_DONE, bus.SEQ_ERR, bus.JOB_IDX,
            bus.JOB_TIME_US, bus.LOOP_CNT};
  endfunction

  initial begin
    int n;
    bus.TICK_1US = 0; bus.CFG_WE = 0; bus.CFG_ADDR = '0; bus.CFG_DATA = '0;
    bus.SEQ_LEN = '0; bus.SEQ_START = 0; bus.SEQ_ABORT = 0; bus.LOOP_EN = 0;
    bus.PROC_BUSY = 0; bus.PROC_DONE = 0;
    cyc(3);
    @(negedge clk);
    check_eq("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Single job: 0x35 -> gamma=1, invgamma=0, bound=1, coeff=3.
    cfg_write(2'd0, 8'h35);
    start(3'd1);
    @(negedge clk);
    check_eq("single_cfg", {60'd0, bus.COEFF_SEL, bus.BOUND_ABS, bus.INVGAMMA_EN, bus.GAMMA_EN},
             {60'd0, 4'd3, 1'b1, 1'b0, 1'b1});
    check_eq("single_busy", 64'(bus.SEQ_BUSY), 64'd1);
    go_cnt = 0; done_cnt = 0;
    wait_go(n);
    check_eq("single_go_latency", 64'(n), 64'd4);
    finish_job(20);
    wait_idle();
    check_eq("single_job_time", 64'(bus.JOB_TIME_US), 64'd20);
    check_eq("single_done_pulses", 64'(done_cnt), 64'd1);
    check_eq("single_go_pulses", 64'(go_cnt), 64'd1);
    check_eq("single_busy_after", {62'd0, bus.SEQ_BUSY, bus.SEQ_DONE}, 64'd0);

    // Three jobs, coefficient banks 1,2,3.
    cfg_write(2'd0, 8'h10);
    cfg_write(2'd1, 8'h20);
    cfg_write(2'd2, 8'h30);
    go_cnt = 0; done_cnt = 0; min_stable = 1000;
    start(3'd3);
    for (int j = 0; j < 3; j++) begin
      wait_go(n);
      bus.PROC_BUSY = 1'b1;
      finish_job(5);
      bus.PROC_BUSY = 1'b0;
    end
    wait_idle();
    check_eq("three_go_pulses", 64'(go_cnt), 64'd3);
    check_eq("three_coeff_seq", {52'd0, coeff_log[0], coeff_log[1], coeff_log[2]}, 64'h123);
    check_eq("three_settle", 64'(min_stable >= 4), 64'd1);
    check_eq("three_job_idx", 64'(bus.JOB_IDX), 64'd2);
    check_eq("three_done_pulses", 64'(done_cnt), 64'd1);

    // Timeout at 50 ticks, then a late DONE must change nothing.
    go_cnt = 0; done_cnt = 0;
    start(3'd1);
    wait_go(n);
    @(posedge clk); #1;
    tick(49);
    @(negedge clk);
    check_eq("timeout_not_yet", {62'd0, bus.SEQ_BUSY, bus.SEQ_ERR == 2'd0}, 64'd3);
    tick(1);
    cyc(3);
    check_eq("timeout_err", 64'(bus.SEQ_ERR), 64'd1);
    check_eq("timeout_busy", 64'(bus.SEQ_BUSY), 64'd0);
    check_eq("timeout_no_done", 64'(done_cnt), 64'd0);
    bus.PROC_DONE = 1'b1; cyc(1); bus.PROC_DONE = 1'b0;
    cyc(3);
    check_eq("late_done_state", {38'd0, bus.SEQ_ERR, bus.SEQ_BUSY, bus.JOB_TIME_US},
             {38'd0, 2'd1, 1'b0, 24'd5});
    check_eq("late_done_go", 64'(go_cnt), 64'd1);

    // Looping: 3 full passes with LOOP_EN, cleared during the 4th.
    go_cnt = 0; done_cnt = 0;
    bus.LOOP_EN = 1'b1;
    start(3'd2);
    for (int j = 0; j < 8; j++) begin
      wait_go(n);
      if (j == 6) bus.LOOP_EN = 1'b0;
      finish_job(2);
    end
    wait_idle();
    check_eq("loop_cnt", 64'(bus.LOOP_CNT), 64'd3);
    check_eq("loop_go_pulses", 64'(go_cnt), 64'd8);
    check_eq("loop_done_pulses", 64'(done_cnt), 64'd1);
    check_eq("loop_coeff_tail", {56'd0, coeff_log[6], coeff_log[7]}, 64'h12);

    // Abort coincident with DONE; table write while busy is dropped.
    go_cnt = 0; done_cnt = 0;
    start(3'd2);
    wait_go(n);
    finish_job(7);
    cfg_write(2'd0, 8'hFF);
    wait_go(n);
    @(posedge clk); #1;
    tick(3);
    bus.PROC_DONE = 1'b1; bus.SEQ_ABORT = 1'b1;
    cyc(1);
    bus.PROC_DONE = 1'b0; bus.SEQ_ABORT = 1'b0;
    @(negedge clk);
    check_eq("abort_state", {38'd0, bus.SEQ_ERR, bus.SEQ_BUSY, bus.JOB_TIME_US},
             {38'd0, 2'd2, 1'b0, 24'd7});
    cyc(20);
    check_eq("abort_go_pulses", 64'(go_cnt), 64'd2);
    check_eq("abort_no_done", 64'(done_cnt), 64'd0);
    start(3'd1);
    @(negedge clk);
    check_eq("busy_write_ignored", {59'd0, bus.COEFF_SEL, bus.GAMMA_EN}, {59'd0, 4'd1, 1'b0});
    cyc(1);
    bus.SEQ_ABORT = 1'b1; cyc(1); bus.SEQ_ABORT = 1'b0;
    @(negedge clk);
    check_eq("abort_in_setup", {61'd0, bus.SEQ_ERR, bus.SEQ_BUSY}, {61'd0, 2'd2, 1'b0});

    // Illegal lengths.
    go_cnt = 0;
    start(3'd0);
    cyc(10);
    check_eq("len0_err", {61'd0, bus.SEQ_ERR, bus.SEQ_BUSY}, {61'd0, 2'd3, 1'b0});
    check_eq("len0_no_go", 64'(go_cnt), 64'd0);
    start(3'd1);
    cyc(1);
    bus.SEQ_ABORT = 1'b1; cyc(1); bus.SEQ_ABORT = 1'b0;
    start(3'd5);
    @(negedge clk);
    check_eq("len5_err", {61'd0, bus.SEQ_ERR, bus.SEQ_BUSY}, {61'd0, 2'd3, 1'b0});

    // Reset mid-SETUP, then a stray DONE in IDLE.
    cfg_write(2'd0, 8'h35);
    start(3'd1);
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_setup", all_outs(), 64'd0);
    done_cnt = 0; go_cnt = 0;
    bus.PROC_DONE = 1'b1; cyc(1); bus.PROC_DONE = 1'b0;
    cyc(10);
    check_eq("rst_stray_done", {62'd0, bus.SEQ_BUSY, 1'b0} | 64'(done_cnt + go_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
